// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-lane BRAM slave.
package bram_pkg;

    // Controller phases: accept in IDLE, count wait states in WAIT, pulse ready in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bram_state_t;

    // Word-index width for a RAM of the given depth.
    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bram_byte_array.sv
// 32-bit wide RAM with four independently writable byte columns and a
// registered read port. Read is read-before-write. The array has no reset.
module bram_byte_array
    import bram_pkg::*;
#(
    parameter int    DEPTH_WORDS = 2048,
    parameter string INIT_FILE   = ""
) (
    input  logic                               clk,
    input  logic                               en,
    input  logic [3:0]                         we,
    input  logic [addr_bits(DEPTH_WORDS)-1:0]  addr,
    input  logic [31:0]                        wdata,
    output logic [31:0]                        rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write plus registered read of the old word, enabled per access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bram_byte_controller.sv
// Single-port BRAM slave on the mem_valid/mem_ready bus with byte strobes,
// configurable base address, depth and wait states, and out-of-range errors.
//
// Handshake: the master raises mem_valid with addr/wdata/wstrb and holds them
// until mem_ready. The request is sampled only on the accept edge (IDLE with
// mem_valid high); mem_ready is a single-cycle pulse WAIT_STATES+1 cycles
// after the accept cycle, and mem_error qualifies that same pulse.
module bram_byte_controller
    import bram_pkg::*;
#(
    parameter int          DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output bram_state_t dbg_state_o
);

    localparam int          AW = addr_bits(DEPTH_WORDS);
    localparam logic [2:0]  WS = 3'(WAIT_STATES);
    // 33-bit bounds so that a window ending at 4 GB does not wrap.
    localparam logic [32:0] LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI = LO + 33'(DEPTH_WORDS) * 33'd4;

    bram_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q;
    logic        rd_ok_q;     // last accept read the array (in range)
    logic        accept;
    logic        in_range;
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic [31:0] arr_rdata;

    // Address decode: window check and word index relative to the base.
    always_comb begin
        in_range = ({1'b0, mem_addr} >= LO) && ({1'b0, mem_addr} < HI);
        off      = mem_addr - BASE_ADDR;
        idx      = AW'(off >> 2);
    end

    // Next-state logic, wait counter and accept/ready strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        mem_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // Nothing is committed to the array while reset is held.
                if (mem_valid && !reset) begin
                    accept = 1'b1;
                    if (WS == 3'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS - 3'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            RESP: begin
                mem_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and per-transaction flags; flags change only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q   <= !in_range;
                rd_ok_q <= in_range;
            end
        end
    end

    // The array output register holds the word read at the last in-range
    // accept; out-of-range accesses and reset present zero instead.
    bram_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (accept && in_range),
        .we    (mem_wstrb),
        .addr  (idx),
        .wdata (mem_wdata),
        .rdata (arr_rdata)
    );

    assign mem_rdata   = rd_ok_q ? arr_rdata : 32'h0;
    assign mem_error   = mem_ready && err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_byte_controller.sv
// Bench for bram_byte_controller: a default instance and a small
// high-base, zero-wait instance share clock and reset.
module tb_bram_byte_controller;
    import bram_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mv  [2];
    logic [31:0] ma  [2];
    logic [31:0] mwd [2];
    logic [3:0]  mws [2];
    logic        mr  [2];
    logic [31:0] mrd [2];
    logic        me  [2];
    bram_state_t st  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_byte_controller u_dut0 (
        .clk(clk), .reset(reset), .mem_valid(mv[0]), .mem_ready(mr[0]),
        .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_wstrb(mws[0]),
        .mem_rdata(mrd[0]), .mem_error(me[0]), .dbg_state_o(st[0])
    );

    bram_byte_controller #(
        .DEPTH_WORDS(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .mem_valid(mv[1]), .mem_ready(mr[1]),
        .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_wstrb(mws[1]),
        .mem_rdata(mrd[1]), .mem_error(me[1]), .dbg_state_o(st[1])
    );

    typedef struct packed {
        logic        dut;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];
    logic [31:0] model [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transaction; returns data, error and cycles from accept edge to ready.
    task automatic do_txn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rd,
                          output logic er, output int lat);
        mv[d] = 1'b1; ma[d] = addr; mwd[d] = wdata; mws[d] = wstrb;
        @(posedge clk); #1;
        lat = 0;
        while (mr[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = mrd[d];
        er = me[d];
        mv[d] = 1'b0;
        mws[d] = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        check("ready_single_cycle", {31'b0, mr[d]}, 32'h0);
        check("rdata_held", mrd[d], rd);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          pulses;

        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; ma[d] = 32'h0; mwd[d] = 32'h0; mws[d] = 4'h0;
        end

        // dut, addr, wdata, wstrb, chk_data, exp_rdata, exp_err
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h1122_3344, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_1FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 1'b1, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_1FFC, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h8000_003C, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_003C, 32'h0,         4'h0, 1'b1, 32'h0BAD_F00D, 1'b0};
        vecs[11] = '{1'b1, 32'h7FFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h8000_0040, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1};

        // Clock/reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", {31'b0, mr[d]}, 32'h0);
            check("reset_error", {31'b0, me[d]}, 32'h0);
            check("reset_rdata", mrd[d], 32'h0);
            check("reset_state", 32'(st[d]), 32'(IDLE));
        end

        // Directed table
        for (int i = 0; i < 13; i++) begin
            int d;
            d = int'(vecs[i].dut);
            do_txn(d, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), (d == 0) ? 32'd2 : 32'd0);
            check($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Reset while waiting after a committed write
        mv[0] = 1'b1; ma[0] = 32'h40; mwd[0] = 32'h5A5A_5A5A; mws[0] = 4'hF;
        @(posedge clk); #1;
        check("abort_in_wait", 32'(st[0]), 32'(WAIT));
        mv[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", {31'b0, mr[0]}, 32'h0);
        check("abort_error", {31'b0, me[0]}, 32'h0);
        check("abort_rdata", mrd[0], 32'h0);
        check("abort_state", 32'(st[0]), 32'(IDLE));
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (mr[0] === 1'b1) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'h0);
        do_txn(0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        check("abort_write_kept", rd, 32'h5A5A_5A5A);

        // Randomised back-to-back traffic against a word/byte model
        for (int k = 0; k < 8; k++) begin
            model[k] = $urandom;
            do_txn(0, 32'h100 + 32'(4 * k), model[k], 4'hF, rd, er, lat);
        end
        for (int i = 0; i < 24; i++) begin
            int          k;
            logic [31:0] wd;
            logic [3:0]  ws;
            logic [31:0] old;
            k  = $urandom_range(0, 7);
            wd = $urandom;
            ws = (i % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            old = model[k];
            do_txn(0, 32'h100 + 32'(4 * k), wd, ws, rd, er, lat);
            for (int b = 0; b < 4; b++)
                if (ws[b]) model[k][8*b +: 8] = wd[8*b +: 8];
            check($sformatf("rand%0d_rdata", i), rd, old);
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("rand%0d_error", i), {31'b0, er}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
